key_code_decoder: RTL and testbench
===================================

Name: key_code_decoder

Overview:
- Receive end of the keypad nibble encoder. The encoder forms encoded = (plain + OFFSET) mod 16, with a default OFFSET of 12 (constant 4'b1100).
- This block captures encoded nibbles on `ld` and recovers each plain digit as (enc − OFFSET) mod 16.
- It buffers NDIG digits. On `st` it compares the buffered sequence against a stored code and reports pass or fail.
- Sits between the encoded keypad bus and the lock/display logic.

Parameters:
- W, 4, digit width in bits.
- NDIG, 4, number of digits per code entry.
- OFFSET, 12, encoder additive offset. The decoder subtracts it mod 2^W.
- CODE, 16'h2719, reference code. The first digit entered is the MSB nibble.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- enc_in  in  W  encoded digit from the encoder.
- ld  in  1  load strobe: capture enc_in this cycle.
- st  in  1  submit strobe: check the buffered entry.
- dout  out  W  last decoded digit (registered).
- dout_vld  out  1  one-cycle pulse when dout updates.
- cnt  out  3  number of digits currently buffered (0..NDIG).
- busy  out  1  high in CHECK and RESULT.
- code_ok  out  1  one-cycle pulse on match.
- code_err  out  1  one-cycle pulse on mismatch or short entry.

Behaviour:
- Reset:
  - clk and clr_n are the block's only clock and reset. Reset is asynchronous, active-low, and is the only reset.
  - On clr_n low, all state clears immediately: dout=0, dout_vld=0, cnt=0, busy=0, code_ok=0, code_err=0, buffer all zero, FSM=IDLE.
- Decode:
  - dec = enc_in + (2^W − OFFSET), truncated to W bits. No carry out is kept.
  - Example: enc 4'hF → 3; enc 4'h0 → 4 (wrap).
- FSM states: IDLE, COLLECT, CHECK, RESULT.
- IDLE or COLLECT, with ld=1 and cnt<NDIG:
  - buf[cnt] ← dec, dout ← dec, cnt ← cnt+1.
  - dout_vld pulses on the cycle after the ld edge (one-cycle latency).
  - FSM → COLLECT.
- ld=1 while cnt==NDIG: ignored. No buffer write, no dout_vld, cnt holds.
- st=1 in IDLE or COLLECT, with ld=0: FSM → CHECK.
- ld and st high in the same cycle:
  - ld is serviced and st is dropped.
  - The bench must re-assert st to submit.
- CHECK (one cycle):
  - match = (cnt==NDIG) && ({buf[0],…,buf[NDIG−1]} == CODE).
  - FSM → RESULT.
- RESULT (one cycle):
  - code_ok=match and code_err=!match, pulsed for exactly one cycle.
  - Buffer and cnt clear to 0. FSM → IDLE.
- Submit timing: st sampled at edge n → CHECK after edge n → result pulse visible after edge n+1.
- busy: high in CHECK and RESULT. ld and st are ignored while busy.
- Short entry: st with cnt<NDIG (including cnt=0) goes through CHECK and RESULT and produces code_err.
- Reset mid-operation: clr_n low in any state aborts the entry. Any result pulse is suppressed and all outputs return to reset values.
- dout holds its last decoded value across submits. It changes only on ld or reset.

Decomposition:
- Shared package key_pkg holds:
  - W_DIGIT and NDIG_DEF.
  - ENC_OFFSET=4'hC, shared with the encoder so both ends use one constant.
  - typedef digit_t = logic [W-1:0].
  - state enum kc_state_t {IDLE, COLLECT, CHECK, RESULT}.
- One sub-module: key_digit_decode, combinational W-bit subtract-offset. It is the mirror of the encoder's adder and is instantiated once.
- FSM, buffer and compare live in the top level.

Test Plan:
- Reset then single ld with enc_in=4'hF: dout=3 and dout_vld=1 for one cycle after the edge; cnt=1.
- Wrap case: ld with enc_in=4'h0 → dout=4. ld with enc_in=4'h3 → dout=7.
- Correct entry: ld E, 3, D, 5 (plain 2, 7, 1, 9), then st → busy for 2 cycles, code_ok pulse 2 edges after st, code_err=0, cnt returns to 0.
- Wrong entry: ld E, 3, D, 6 (last digit 10), then st → code_err pulse, code_ok=0, buffer cleared.
- Short entry and overflow:
  - Two lds then st → code_err.
  - Five lds → cnt saturates at 4 and the fifth produces no dout_vld.
  - ld and st in the same cycle → digit stored, no check started.
- Reset mid-entry: three lds, then clr_n low asynchronously between edges → cnt=0 and dout=0 immediately. A following st with no digits → code_err.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: constants, digit type and FSM state shared by the keypad encoder/decoder pair.
package key_pkg;
  localparam int W_DIGIT = 4;
  localparam int NDIG_DEF = 4;
  localparam int CNT_W = 3;
  localparam logic [3:0] ENC_OFFSET = 4'hC;
  typedef logic [W_DIGIT-1:0] digit_t;
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, RESULT} kc_state_t;
endpackage

// File: rtl/key_code_decoder_if.sv
// key_code_decoder_if: encoded keypad bus plus decoder status; master drives keys, slave is the decoder.
interface key_code_decoder_if import key_pkg::*; #(parameter int W = W_DIGIT, parameter int CW = CNT_W);
  logic [W-1:0] enc_in;
  logic ld;
  logic st;
  logic [W-1:0] dout;
  logic dout_vld;
  logic [CW-1:0] cnt;
  logic busy;
  logic code_ok;
  logic code_err;
  modport master(output enc_in, ld, st, input dout, dout_vld, cnt, busy, code_ok, code_err);
  modport slave(input enc_in, ld, st, output dout, dout_vld, cnt, busy, code_ok, code_err);
endinterface

// File: rtl/key_digit_decode.sv
// key_digit_decode: undoes the encoder's add by adding the two's complement of the offset mod 2^W.
module key_digit_decode #(parameter int W = 4, parameter int OFFSET = 12) (
  input  logic [W-1:0] i_enc,
  output logic [W-1:0] o_dec
);
  localparam logic [W-1:0] ADD = W'((2 ** W) - OFFSET);
  assign o_dec = i_enc + ADD;
endmodule

// File: rtl/key_code_decoder.sv
// key_code_decoder: buffers NDIG decoded keypad digits and checks them against CODE on submit.
module key_code_decoder import key_pkg::*; #(
  parameter int W = W_DIGIT,
  parameter int NDIG = NDIG_DEF,
  parameter int OFFSET = int'(ENC_OFFSET),
  parameter logic [NDIG*W-1:0] CODE = 16'h2719
) (
  input logic clk,
  input logic clr_n,
  key_code_decoder_if.slave bus
);
  kc_state_t r_state;
  logic [0:NDIG-1][W-1:0] r_buf;
  logic [W-1:0] r_dout;
  logic r_dout_vld;
  logic [CNT_W-1:0] r_cnt;
  logic r_ok;
  logic r_err;
  logic [W-1:0] w_dec;
  logic w_match;
  key_digit_decode #(.W(W), .OFFSET(OFFSET)) u_dec (.i_enc(bus.enc_in), .o_dec(w_dec));
  // r_buf[0] lands in the MSB nibble, so first-entered digit lines up with CODE's MSB
  assign w_match = (r_cnt == CNT_W'(NDIG)) && (r_buf == CODE);
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_dout <= '0;
      r_dout_vld <= 1'b0;
      r_cnt <= '0;
      r_ok <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      r_ok <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (bus.ld) begin
            if (r_cnt < CNT_W'(NDIG)) begin
              for (int i = 0; i < NDIG; i++)
                if (CNT_W'(i) == r_cnt) r_buf[i] <= w_dec;
              r_dout <= w_dec;
              r_dout_vld <= 1'b1;
              r_cnt <= r_cnt + CNT_W'(1);
              r_state <= COLLECT;
            end
          end else if (bus.st) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_ok <= w_match;
          r_err <= !w_match;
          r_state <= RESULT;
        end
        RESULT: begin
          r_buf <= '0;
          r_cnt <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.dout = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.cnt = r_cnt;
  assign bus.busy = (r_state == CHECK) || (r_state == RESULT);
  assign bus.code_ok = r_ok;
  assign bus.code_err = r_err;
endmodule

// File: tb/tb_key_code_decoder.sv
// tb_key_code_decoder: table-driven entries with scoreboard queues for decoded digits and results.
module tb_key_code_decoder;
  import key_pkg::*;
  typedef struct packed {logic [3:0] enc; logic [3:0] dec;} vec_t;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  digit_t exp_dout_q[$];
  bit exp_ok_q[$];
  vec_t tbl[12];
  bit tbl_ok[3];
  key_code_decoder_if bus();
  key_code_decoder dut(.clk(clk), .clr_n(clr_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (clr_n && bus.dout_vld) begin
      if (exp_dout_q.size() == 0) chk("unexpected dout_vld", 1, 0);
      else chk("dout", int'(bus.dout), int'(exp_dout_q.pop_front()));
    end
    if (clr_n && (bus.code_ok || bus.code_err)) begin
      chk("ok_err_exclusive", int'(bus.code_ok && bus.code_err), 0);
      if (exp_ok_q.size() == 0) chk("unexpected result pulse", 1, 0);
      else chk("code_ok", int'(bus.code_ok), int'(exp_ok_q.pop_front()));
    end
  end
  task automatic do_ld(input logic [3:0] enc, input logic [3:0] dec, input bit accepted);
    @(negedge clk);
    bus.enc_in = enc;
    bus.ld = 1'b1;
    if (accepted) exp_dout_q.push_back(dec);
    @(negedge clk);
    bus.ld = 1'b0;
  endtask
  task automatic do_st(input bit ok);
    @(negedge clk);
    bus.st = 1'b1;
    exp_ok_q.push_back(ok);
    @(negedge clk);
    bus.st = 1'b0;
    chk("busy_check", int'(bus.busy), 1);
    @(negedge clk);
    chk("busy_result", int'(bus.busy), 1);
    @(negedge clk);
    chk("busy_done", int'(bus.busy), 0);
    chk("cnt_cleared", int'(bus.cnt), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl = '{'{4'hF, 4'h3}, '{4'h0, 4'h4}, '{4'h3, 4'h7}, '{4'hC, 4'h0},
            '{4'hE, 4'h2}, '{4'h3, 4'h7}, '{4'hD, 4'h1}, '{4'h5, 4'h9},
            '{4'hE, 4'h2}, '{4'h3, 4'h7}, '{4'hD, 4'h1}, '{4'h6, 4'hA}};
    tbl_ok = '{1'b0, 1'b1, 1'b0};
    bus.enc_in = '0;
    bus.ld = 1'b0;
    bus.st = 1'b0;
    #3;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_vld", int'(bus.dout_vld), 0);
    chk("rst_ok_err", int'({bus.code_ok, bus.code_err}), 0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do_ld(tbl[i].enc, tbl[i].dec, 1'b1);
      chk("cnt_inc", int'(bus.cnt), (i % 4) + 1);
      if (i % 4 == 3) begin
        do_st(tbl_ok[i / 4]);
        chk("dout_hold", int'(bus.dout), int'(tbl[i].dec));
      end
    end
    do_ld(4'hE, 4'h2, 1'b1);
    do_ld(4'h3, 4'h7, 1'b1);
    do_st(1'b0);
    do_ld(4'hE, 4'h2, 1'b1);
    do_ld(4'h3, 4'h7, 1'b1);
    do_ld(4'hD, 4'h1, 1'b1);
    do_ld(4'h5, 4'h9, 1'b1);
    do_ld(4'hB, 4'hF, 1'b0);
    chk("overflow_cnt", int'(bus.cnt), 4);
    chk("overflow_dout", int'(bus.dout), 9);
    do_st(1'b1);
    @(negedge clk);
    bus.enc_in = 4'hE;
    bus.ld = 1'b1;
    bus.st = 1'b1;
    exp_dout_q.push_back(4'h2);
    @(negedge clk);
    bus.ld = 1'b0;
    bus.st = 1'b0;
    chk("ldst_cnt", int'(bus.cnt), 1);
    chk("ldst_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("ldst_busy_late", int'(bus.busy), 0);
    do_st(1'b0);
    do_ld(4'h1, 4'h5, 1'b1);
    do_ld(4'h2, 4'h6, 1'b1);
    do_ld(4'h4, 4'h8, 1'b1);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_cnt", int'(bus.cnt), 0);
    chk("arst_dout", int'(bus.dout), 0);
    @(negedge clk);
    clr_n = 1'b1;
    do_st(1'b0);
    do_ld(4'hE, 4'h2, 1'b1);
    @(negedge clk);
    bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    chk("abort_busy_before", int'(bus.busy), 1);
    #1 clr_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_cnt", int'(bus.cnt), 0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pending_digits", exp_dout_q.size(), 0);
    chk("pending_results", exp_ok_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
